// File: rtl/ofmap_writer.sv
// ofmap_writer: scatters im2col-ordered GEMM results (pixel major, channel minor)
// into planar CHW output memory, deriving O=(N-K)/S+1 and P=O*O iteratively.
module ofmap_writer #(
  parameter int TENSOR_W   = 8,
  parameter int CHANNELS_W = 8,
  parameter int STRIDE_W   = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [TENSOR_W-1:0]   tensor_size,
  input  logic [TENSOR_W-1:0]   kernel_size,
  input  logic [CHANNELS_W-1:0] channels,
  input  logic [STRIDE_W-1:0]   stride,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  done
);

  localparam int P_W   = 2 * TENSOR_W;
  localparam int DIV_W = (TENSOR_W > STRIDE_W) ? TENSOR_W : STRIDE_W;
  localparam int CB_W  = CHANNELS_W + P_W;
  localparam int SUM_W = ((ADDR_W > CB_W) ? ADDR_W : CB_W) + 2;

  typedef enum logic [2:0] {IDLE, DIV, MUL, RUN, DONE} state_t;
  state_t state, state_next;

  logic [STRIDE_W-1:0]   stride_r;
  logic [CHANNELS_W-1:0] chan_r;
  logic [ADDR_W-1:0]     base_r;
  logic [DIV_W-1:0]      rem;
  logic [TENSOR_W-1:0]   q, o_size, cnt;
  logic [P_W-1:0]        p_size, pix;
  logic [CHANNELS_W-1:0] oc;
  logic [CB_W-1:0]       chan_base;
  logic                  job_illegal, div_step, mul_last, accept, last_chan, last_beat;
  logic [SUM_W-1:0]      addr_full;

  assign job_illegal = (kernel_size == '0) || (stride == '0) || (channels == '0) ||
                       (kernel_size > tensor_size);
  assign div_step    = rem >= DIV_W'(stride_r);
  assign mul_last    = cnt == (o_size - TENSOR_W'(1));
  assign accept      = in_valid && in_ready;
  assign last_chan   = oc == (chan_r - CHANNELS_W'(1));
  assign last_beat   = last_chan && (pix == (p_size - P_W'(1)));
  // oc*P is carried in chan_base, so the address is a plain three-way add
  assign addr_full   = SUM_W'(base_r) + SUM_W'(chan_base) + SUM_W'(pix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = job_illegal ? DONE : DIV;
      DIV:     if (!div_step) state_next = MUL;
      MUL:     if (mul_last) state_next = RUN;
      RUN:     if (accept && last_beat) state_next = DONE;
      DONE:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready rises one cycle after entering RUN and drops with the final accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      stride_r  <= '0;
      chan_r    <= '0;
      base_r    <= '0;
      rem       <= '0;
      q         <= '0;
      o_size    <= '0;
      cnt       <= '0;
      p_size    <= '0;
      pix       <= '0;
      oc        <= '0;
      chan_base <= '0;
    end else begin
      in_ready <= (state == RUN) && (state_next == RUN);
      done     <= (state == DONE);
      wr_en    <= accept;
      if (accept) begin
        wr_addr <= addr_full[ADDR_W-1:0];
        wr_data <= in_data;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            stride_r <= stride;
            chan_r   <= channels;
            base_r   <= base_addr;
            rem      <= DIV_W'(tensor_size - kernel_size);
            q        <= '0;
          end
        end
        DIV: begin
          if (div_step) begin
            rem <= rem - DIV_W'(stride_r);
            q   <= q + TENSOR_W'(1);
          end else begin
            o_size <= q + TENSOR_W'(1);
            p_size <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          p_size    <= p_size + P_W'(o_size);
          cnt       <= cnt + TENSOR_W'(1);
          oc        <= '0;
          pix       <= '0;
          chan_base <= '0;
        end
        RUN: begin
          if (accept) begin
            if (last_chan) begin
              oc        <= '0;
              chan_base <= '0;
              pix       <= pix + P_W'(1);
            end else begin
              oc        <= oc + CHANNELS_W'(1);
              chan_base <= chan_base + CB_W'(p_size);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// tb_ofmap_writer: scoreboard bench; expected CHW writes are queued at each accept
// and popped against wr_en, with startup, done and reset timing checked alongside.
module tb_ofmap_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  tensor_size, kernel_size, channels;
  logic [3:0]  stride;
  logic [15:0] base_addr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, wr_en, done;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   vecCount = 0;
  int   errCount = 0;

  ofmap_writer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tensor_size(tensor_size), .kernel_size(kernel_size),
    .channels(channels), .stride(stride), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one job; all outputs are sampled on the falling edge, j counts rising edges
  // since the edge that sampled enable.
  task automatic applyStimulus(input int n, input int k, input int s, input int c,
                               input logic [15:0] base, input bit bubbles,
                               input bit dropEarly, input int abortAfter);
    int   o, pp, total, sent, writes, readyJ, doneJ, lastWrJ;
    bit   legal, prevAcc, finished;
    exp_t e;
    legal = (k != 0) && (s != 0) && (c != 0) && (k <= n);
    o     = legal ? (n - k) / s + 1 : 0;
    pp    = o * o;
    total = pp * c;
    sent = 0; writes = 0; readyJ = -1; doneJ = -1; lastWrJ = -1;
    prevAcc = 1'b0; finished = 1'b0;
    expQ.delete();
    $display("[TB] job N=%0d K=%0d S=%0d C=%0d base=0x%0h", n, k, s, c, base);

    @(negedge clk);
    tensor_size = 8'(n); kernel_size = 8'(k); stride = 4'(s); channels = 8'(c);
    base_addr = base; enable = 1'b1; in_valid = 1'b0;
    @(posedge clk);

    for (int j = 0; j < 3000 && !finished; j++) begin
      @(negedge clk);
      if (wr_en) begin
        writes++;
        lastWrJ = j;
        if (expQ.size() == 0) checkOutput("spuriousWrite", 32'd1, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("wrAddr", {16'd0, wr_addr}, {16'd0, e.addr});
          checkOutput("wrData", wr_data, e.data);
        end
      end
      checkOutput("wrAfterAccept", {31'd0, wr_en}, {31'd0, prevAcc});
      if (!legal) checkOutput("readyIllegal", {31'd0, in_ready}, 32'd0);
      else if (in_ready && readyJ < 0) readyJ = j;
      if (done && doneJ < 0) doneJ = j;

      if (abortAfter > 0 && sent >= abortAfter) begin
        in_valid = 1'b0; enable = 1'b0; rst = 1'b1;
        #1;
        checkOutput("rstWrEn",   {31'd0, wr_en},    32'd0);
        checkOutput("rstWrAddr", {16'd0, wr_addr},  32'd0);
        checkOutput("rstWrData", wr_data,           32'd0);
        checkOutput("rstReady",  {31'd0, in_ready}, 32'd0);
        checkOutput("rstDone",   {31'd0, done},     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        return;
      end

      if (doneJ >= 0) finished = 1'b1;
      prevAcc  = 1'b0;
      in_valid = (sent < total) && (!bubbles || (j % 2 == 0));
      in_data  = $urandom;
      if (dropEarly && sent > 0) enable = 1'b0;
      if (in_valid && in_ready) begin
        e.addr = 16'(int'(base) + (sent % c) * pp + sent / c);
        e.data = in_data;
        expQ.push_back(e);
        sent++;
        prevAcc = 1'b1;
      end
    end
    in_valid = 1'b0;

    if (!finished) checkOutput("jobTimeout", 32'd0, 32'd1);
    checkOutput("writeCount", writes, total);
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    if (legal) begin
      checkOutput("readyLatency", readyJ, 2 * o + 1);
      checkOutput("doneTiming", doneJ, lastWrJ + 1);
    end else begin
      checkOutput("doneIllegal", doneJ, 32'd1);
    end

    if (dropEarly) begin
      @(negedge clk);
      checkOutput("donePulse", {31'd0, done}, 32'd0);
    end else begin
      repeat (3) begin
        @(negedge clk);
        checkOutput("doneHeld",   {31'd0, done},     32'd1);
        checkOutput("noRestart",  {31'd0, in_ready}, 32'd0);
        checkOutput("noLateWrite", {31'd0, wr_en},   32'd0);
      end
      enable = 1'b0;
      doneJ = -1;
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        if (!done) begin
          doneJ = t;
          break;
        end
      end
      checkOutput("doneRelease", doneJ, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    tensor_size = '0; kernel_size = '0; channels = '0; stride = '0; base_addr = '0;
    #12;
    checkOutput("resetReady",  {31'd0, in_ready}, 32'd0);
    checkOutput("resetWrEn",   {31'd0, wr_en},    32'd0);
    checkOutput("resetWrAddr", {16'd0, wr_addr},  32'd0);
    checkOutput("resetWrData", wr_data,           32'd0);
    checkOutput("resetDone",   {31'd0, done},     32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8, 2, 2, 4, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus(7, 3, 3, 1, 16'h0100, 1'b0, 1'b0, 0);
    applyStimulus(8, 2, 2, 4, 16'h0000, 1'b1, 1'b0, 0);
    applyStimulus(8, 9, 2, 4, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus(8, 2, 0, 4, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus(8, 2, 2, 4, 16'h0000, 1'b0, 1'b0, 20);
    applyStimulus(8, 2, 2, 4, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus(4, 1, 1, 1, 16'hFFF8, 1'b0, 1'b0, 0);
    applyStimulus(8, 2, 2, 4, 16'h0040, 1'b0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
